// File: rtl/instr_loader_pkg.sv
// Shared state encoding and constants for the boot-time instruction loader.
package instr_loader_pkg;

    localparam int          STATE_W           = 3;
    localparam int          WORD_BYTES        = 4;
    localparam int          IDX_W             = $clog2(WORD_BYTES);
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte index plus word register, with a
// word_complete pulse on acceptance of the final byte of a word.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_complete
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        word_next                        = word_q;
        word_next[{idx_q, 3'b000} +: 8]  = byte_data;
        idx_d                            = idx_q;
        word_d                           = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_en) begin
            idx_d  = idx_q + IDX_W'(1);
            word_d = word_next;
        end
    end

    assign word_complete = byte_en && (idx_q == IDX_W'(WORD_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length header + little-endian words into instruction memory,
// core held in reset until DONE. Optional checksum byte: INSTR_LOADER_CSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_rst,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef INSTR_LOADER_CSUM_EN
    localparam state_e LAST_STATE = ST_CSUM;
`else
    localparam state_e LAST_STATE = ST_DONE;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_loaded_q, words_loaded_d;
    logic             byte_ready_q, byte_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef INSTR_LOADER_CSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             restart, accept, last_word, word_complete;
    logic [CNT_W-1:0] hdr_count, words_inc;
    logic [31:0]      word_next;

    assign restart   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign accept    = byte_valid && byte_ready_q;
    assign hdr_count = CNT_W'({byte_data, count_q[7:0]});
    assign words_inc = words_loaded_q + CNT_W'(1);
    assign last_word = (words_inc == count_q);

    instr_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (restart),
        .byte_en      (accept && (state_q == ST_DATA)),
        .byte_data    (byte_data),
        .word_next    (word_next),
        .word_complete(word_complete)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_HDR_LO;
            ST_HDR_LO: if (accept) state_d = ST_HDR_HI;
            ST_HDR_HI: begin
                if (accept) begin
                    if (hdr_count > DEPTH_C)      state_d = ST_ERROR;
                    else if (hdr_count == '0)     state_d = LAST_STATE;
                    else                          state_d = ST_DATA;
                end
            end
            ST_DATA:  if (word_complete) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? LAST_STATE : ST_DATA;
`ifdef INSTR_LOADER_CSUM_EN
            ST_CSUM:  if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with state_q.
    always_comb begin
        count_d        = count_q;
        words_loaded_d = words_loaded_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        imem_we_d      = (state_d == ST_WRITE);
        done_d         = (state_d == ST_DONE);
        error_d        = (state_d == ST_ERROR);
        byte_ready_d   = (state_d inside {ST_HDR_LO, ST_HDR_HI, ST_DATA});
`ifdef INSTR_LOADER_CSUM_EN
        byte_ready_d   = byte_ready_d || (state_d == ST_CSUM);
        csum_d         = csum_q;
        if (restart)                             csum_d = '0;
        else if (accept && (state_q == ST_DATA)) csum_d = csum_q ^ byte_data;
`endif
        if (restart) begin
            count_d        = '0;
            words_loaded_d = '0;
        end
        if (accept && (state_q == ST_HDR_LO)) count_d[7:0] = byte_data;
        if (accept && (state_q == ST_HDR_HI)) count_d      = hdr_count;
        if (word_complete) begin
            imem_addr_d  = BASE_ADDR + (32'(words_loaded_q) << 2);
            imem_wdata_d = word_next;
        end
        if (state_q == ST_WRITE) words_loaded_d = words_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            count_q        <= count_d;
            words_loaded_q <= words_loaded_d;
            byte_ready_q   <= byte_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef INSTR_LOADER_CSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;
    assign core_rst     = rst || (state_q != ST_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven loads with a write scoreboard,
// plus hand-written reset, depth-boundary and checksum sequences.
module tb_instr_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 256;
    localparam int          CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_ready, imem_we, core_rst, done, error;
    logic [31:0]      imem_addr, imem_wdata;
    logic [CNT_W-1:0] words_loaded;

    instr_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst    (core_rst),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string        tag;
        logic [127:0] bytes;   // first byte in [127:120]
        int           n;
        bit           gaps;
        bit           exp_done;
        bit           exp_error;
        int           exp_wl;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    vec_t       vecs[5];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] stream_xor();
        logic [7:0] x = 8'h00;
        for (int i = 2; i < stream_q.size(); i++) x ^= stream_q[i];
        return x;
    endfunction

    // Reference model: header count, then little-endian words at BASE + 4*index.
    task automatic push_expected();
        int  cnt;
        wr_t e;
        cnt = int'({stream_q[1], stream_q[0]});
        if (cnt > DEPTH) return;
        for (int w = 0; w < cnt; w++) begin
            e.addr = BASE + 32'(4 * w);
            e.data = {stream_q[2+4*w+3], stream_q[2+4*w+2], stream_q[2+4*w+1], stream_q[2+4*w]};
            exp_q.push_back(e);
        end
    endtask

    // Write monitor: every imem_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && imem_we) begin : mon
            wr_t e;
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e.addr);
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the last accepted byte.
    task automatic send_stream(input bit gaps);
        int tries;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_data  = stream_q[i];
            tries      = 0;
            while (!byte_ready && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (!byte_ready) begin
                check("ready_timeout", 32'(byte_ready), 32'd1);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input bit gaps, input bit exp_done,
                            input bit exp_error, input int exp_wl);
        int waited;
        push_expected();
        pulse_start();
        check({tag, "_restart_done"}, 32'(done), 32'd0);
        check({tag, "_restart_error"}, 32'(error), 32'd0);
        check({tag, "_restart_wl"}, 32'(words_loaded), 32'd0);
        check({tag, "_restart_core_rst"}, 32'(core_rst), 32'd1);
        check({tag, "_restart_ready"}, 32'(byte_ready), 32'd1);
        send_stream(gaps);
        if (exp_error) check({tag, "_error_next_edge"}, 32'(error), 32'd1);
        waited = 0;
        while (!(done || error) && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_error));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_wl));
        check({tag, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] b;

        vecs[0] = '{"two_word",   128'h0200_1305_1000_B305_A500_0000_0000_0000, 10, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{"overflow",   128'h0101_0000_0000_0000_0000_0000_0000_0000,  2, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{"zero_hdr",   128'h0000_0000_0000_0000_0000_0000_0000_0000,  2, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{"three_gaps", 128'h0300_1305_1000_B305_A500_9300_F0FF_0000, 14, 1'b1, 1'b1, 1'b0, 3};
        vecs[4] = '{"three_flat", 128'h0300_1305_1000_B305_A500_9300_F0FF_0000, 14, 1'b0, 1'b1, 1'b0, 3};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            b = vecs[r].bytes;
            stream_q.delete();
            for (int i = 0; i < vecs[r].n; i++) stream_q.push_back(b[127-8*i -: 8]);
`ifdef INSTR_LOADER_CSUM_EN
            if (!vecs[r].exp_error) stream_q.push_back(stream_xor());
`endif
            run_load(vecs[r].tag, vecs[r].gaps, vecs[r].exp_done, vecs[r].exp_error, vecs[r].exp_wl);
        end

        // Header exactly equal to DEPTH is legal and fills the whole memory.
        stream_q.delete();
        stream_q.push_back(8'(DEPTH));
        stream_q.push_back(8'(DEPTH >> 8));
        for (int w = 0; w < DEPTH; w++) begin
            stream_q.push_back(8'(w));
            stream_q.push_back(~8'(w));
            stream_q.push_back(8'h5A);
            stream_q.push_back(8'(w) ^ 8'h3C);
        end
`ifdef INSTR_LOADER_CSUM_EN
        stream_q.push_back(stream_xor());
`endif
        run_load("depth_full", 1'b0, 1'b1, 1'b0, DEPTH);

        // Reset after two bytes of the first word, then a clean reload.
        stream_q.delete();
        stream_q = '{8'h01, 8'h00, 8'h13, 8'h05};
        pulse_start();
        send_stream(1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stream_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
`ifdef INSTR_LOADER_CSUM_EN
        stream_q.push_back(8'h06);
`endif
        run_load("after_rst", 1'b0, 1'b1, 1'b0, 1);

`ifdef INSTR_LOADER_CSUM_EN
        stream_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
        run_load("csum_good", 1'b0, 1'b1, 1'b0, 1);
        stream_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
        run_load("csum_bad", 1'b0, 1'b0, 1'b1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader directly upstream of the 5-stage RV32I core and its instruction memory.
- Receives a byte stream (length header, then little-endian instruction words) over a valid/ready handshake.
- Writes each assembled word into instruction memory through a dedicated write port.
- Holds the core in reset until the load completes successfully, so the PC register starts fetching from BASE_ADDR with a valid image.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
DEPTH, 256, instruction-memory capacity in 32-bit words; header counts above this are errors
CNT_W, 16, width of the word-count header and word counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
byte_valid  input  1  upstream byte available
byte_data  input  8  upstream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  32  byte address of the write, BASE_ADDR + 4*index
imem_wdata  output  32  assembled instruction word
core_rst  output  1  reset to the core pipeline; high unless state is DONE
done  output  1  load completed successfully
error  output  1  load aborted (count overflow or checksum mismatch)
words_loaded  output  CNT_W  number of words written in the current or last load

Behaviour:
- Reset state. rst is asynchronous and active-high. On reset the state is IDLE and every registered output is 0: byte_ready, imem_we, imem_addr, imem_wdata, done, error, words_loaded.
- core_rst. Driven as rst OR (state != DONE), so it is 1 during reset and during any load.
- Handshake. A byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is 1 only in HDR_LO, HDR_HI and DATA, plus CSUM when the optional feature is enabled.
- IDLE.
  - start moves to HDR_LO.
  - On that transition, clear done, error, words_loaded and the byte index.
- HDR_LO. Accepted byte goes to count[7:0]; move to HDR_HI.
- HDR_HI. Accepted byte goes to count[15:8], then:
  - count > DEPTH: go to ERROR.
  - count == 0: go to DONE, or to CSUM with the feature enabled.
  - otherwise: go to DATA.
- DATA.
  - Bytes fill the word little-endian: byte index 0 to bits [7:0], through index 3 to bits [31:24].
  - On acceptance of index 3, go to WRITE.
- WRITE (exactly 1 cycle).
  - Registered outputs: imem_we=1, imem_addr=BASE_ADDR+4*words_loaded, imem_wdata=assembled word.
  - words_loaded increments at the end of this cycle.
  - If the incremented words_loaded == count, go to DONE (CSUM with the feature); otherwise return to DATA.
  - byte_ready is 0 in WRITE, giving one bubble per word.
  - imem_we is 1 for exactly one cycle per word, in the cycle after the 4th byte is accepted.
- DONE.
  - done=1 and core_rst=0 from the first cycle in DONE.
  - The core comes out of reset on the same edge that done rises.
- ERROR. error=1; core_rst stays 1.
- start in DONE or ERROR restarts the load: go to HDR_LO, clear flags, and reassert core_rst. start in any other state is ignored.
- Reset mid-load returns to IDLE immediately. Words already written stay in memory; words_loaded clears.
- The address arithmetic is 32-bit and wraps modulo 2^32; no check beyond DEPTH is needed because the count is bounded.

Optional Feature:
INSTR_LOADER_CSUM_EN
- Defined:
  - A running XOR of all data bytes is kept.
  - After the last word (or the header, when count is 0) the FSM enters CSUM and accepts one checksum byte.
  - If it equals the running XOR, go to DONE; otherwise go to ERROR.
- Undefined: the CSUM state and checksum register do not exist, and the last WRITE (or a zero header) goes straight to DONE.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, HDR_LO, HDR_HI, DATA, WRITE, CSUM, DONE, ERROR) and its encoding width;
  - constants WORD_BYTES=4 and default BASE_ADDR.
- One natural sub-module, byte_packer: the 2-bit byte index plus the 32-bit little-endian shift/assemble register, with a word_complete pulse.
- The FSM, counters and output registers stay in instr_loader.

Test Plan:
- Load of 2 words: bytes 02 00 13 05 10 00 B3 05 A5 00 with byte_valid held high. Required:
  - imem_we pulses write 32'h00100513 at address 0, then 32'h00A505B3 at address 4;
  - done=1 and core_rst falls after the second WRITE;
  - words_loaded=2.
- Header 01 01 (257) with DEPTH=256. Required: ERROR on the next edge, error=1, core_rst=1, no imem_we pulses.
- Header 00 00. Required: DONE with no writes, words_loaded=0 (with the feature, the checksum byte must be 00).
- Randomized byte_valid gaps during a 3-word load. Required: the writes are identical to the gap-free case, and byte_ready=0 in every WRITE cycle.
- Assert rst after 2 of 4 bytes of word 1. Required:
  - the FSM returns to IDLE and all outputs are 0;
  - a new start plus a full stream loads correctly from address 0.
- With INSTR_LOADER_CSUM_EN:
  - 1 word 13 05 10 00 followed by checksum 06 gives DONE;
  - the same stream with checksum 07 gives ERROR and core_rst held at 1.
